ram_boot_loader: RTL

- Sits between the processor's data-RAM port and the RAM.
- After start, it takes a byte stream (valid/ready), packs 4 bytes into each little-endian 32-bit word, and writes the words to RAM addresses 0..N-1.
- The processor is held disabled while loading.
- Once loading is done, the processor's RAM requests pass straight through to the RAM.

---
 rtl/ram_boot_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ram_boot_loader.sv
// Boot loader that streams bytes into data RAM as little-endian words,
// then hands the RAM port over to the processor.
module ram_boot_loader #(
   parameter int unsigned NUM_RAM_ADDRESS = 256,
   parameter int unsigned ADDR_W          = $clog2(NUM_RAM_ADDRESS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              start,
   input  logic [ADDR_W:0]   load_words,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic [ADDR_W-1:0] proc_ram_address,
   input  logic [31:0]       proc_ram_data_write,
   input  logic              proc_ram_enable,
   input  logic              proc_ram_read_write,
   output logic [ADDR_W-1:0] ram_address,
   output logic [31:0]       ram_data_write,
   output logic              ram_enable,
   output logic              ram_read_write,
   output logic              proc_enable,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned LEN_W = ADDR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_byte_cnt;
   logic [ADDR_W-1:0] r_word_cnt;
   logic [LEN_W-1:0]  r_len;
   logic [31:0]       r_shift;
   logic              r_byte_ready;
   logic              r_busy;
   logic              r_done;
   logic              r_error;

   logic              w_can_start;
   logic              w_len_bad;
   logic              w_len_zero;
   logic              w_accept;
   logic              w_last;

   assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_len_bad   = load_words > LEN_W'(NUM_RAM_ADDRESS);
   assign w_len_zero  = (load_words == '0);
   assign w_accept    = byte_valid && r_byte_ready;
   assign w_last      = ({1'b0, r_word_cnt} == (r_len - LEN_W'(1)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start && !w_len_bad) w_next = w_len_zero ? S_DONE : S_COLLECT;
         end
         S_COLLECT: begin
            if (w_accept && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
         end
         S_WRITE: w_next = w_last ? S_DONE : S_COLLECT;
         default: w_next = S_IDLE;
      endcase
   end

   // Status flags are registered copies of the next state; datapath packs bytes LSB first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_byte_cnt   <= '0;
         r_word_cnt   <= '0;
         r_len        <= '0;
         r_shift      <= '0;
         r_byte_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_byte_ready <= (w_next == S_COLLECT);
         r_busy       <= (w_next == S_COLLECT) || (w_next == S_WRITE);
         r_done       <= (w_next == S_DONE);
         if (w_can_start && start) begin
            if (w_len_bad) begin
               r_error <= 1'b1;
            end else begin
               r_error    <= 1'b0;
               r_len      <= load_words;
               r_word_cnt <= '0;
               r_byte_cnt <= '0;
            end
         end
         if (w_accept) begin
            r_shift    <= {byte_in, r_shift[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
         end
         if ((r_state == S_WRITE) && !w_last) begin
            r_word_cnt <= r_word_cnt + ADDR_W'(1);
            r_byte_cnt <= '0;
         end
      end
   end

   assign byte_ready  = r_byte_ready;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;
   assign proc_enable = r_done & enable;

   // RAM port owner is chosen by the registered state; processor path is combinational.
   always_comb begin
      ram_enable     = 1'b0;
      ram_read_write = 1'b0;
      ram_address    = r_word_cnt;
      ram_data_write = r_shift;
      if (r_state == S_DONE) begin
         ram_enable     = proc_ram_enable;
         ram_read_write = proc_ram_read_write;
         ram_address    = proc_ram_address;
         ram_data_write = proc_ram_data_write;
      end else if (r_state == S_WRITE) begin
         ram_enable     = 1'b1;
         ram_read_write = 1'b1;
      end
   end

endmodule
